// File: rtl/copro_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | copro_pkg : shared types and widths for the multiply co-proc host   |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package copro_pkg;

  localparam int CP_W        = 32;
  localparam int PROD_W      = 64;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PUSH_A = 4'd1,
    ST_PUSH_B = 4'd2,
    ST_START  = 4'd3,
    ST_BUSY   = 4'd4,
    ST_RD_HI  = 4'd5,
    ST_RD_LO  = 4'd6,
    ST_CORR   = 4'd7,
    ST_DONE   = 4'd8
  } state_e;

endpackage : copro_pkg
`default_nettype wire

// File: rtl/copro_host.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | copro_host : sequences push/start/ready/pop on the multiply co-proc |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
module copro_host
  import copro_pkg::*;
#(
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int TOW     = $clog2(TIMEOUT + 1)
) (
  input  logic              ck,
  input  logic              rb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CP_W-1:0]   op_a,
  input  logic [CP_W-1:0]   op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res,
  output logic              res_err,
  output logic              fault,
  output logic              cp_start,
  input  logic              cp_ready,
  output logic              cp_dpsh,
  output logic [CP_W-1:0]   cp_dinp,
  output logic              cp_dpop,
  input  logic [CP_W-1:0]   cp_dout
);

  state_e              state_q, state_d;
  logic [CP_W-1:0]     a_q, a_d, b_q, b_d;
  logic [CP_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CP_W-1:0]     prev_hi_q, prev_hi_d;
  logic [PROD_W-1:0]   res_q, res_d;
  logic                err_q, err_d;
  logic                fault_q, fault_d;
  logic [TOW-1:0]      wd_q, wd_d;

  always_ff @(posedge ck) begin
    if (rb) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      prev_hi_q <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      fault_q   <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prev_hi_q <= prev_hi_d;
      res_q     <= res_d;
      err_q     <= err_d;
      fault_q   <= fault_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prev_hi_d = prev_hi_q;
    res_d     = res_q;
    err_d     = err_q;
    fault_d   = fault_q;
    wd_d      = wd_q;
    cp_dpsh   = 1'b0;
    cp_dinp   = '0;
    cp_start  = 1'b0;
    cp_dpop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !fault_q) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = ST_PUSH_A;
        end
      end
      ST_PUSH_A: begin
        cp_dpsh = 1'b1;
        cp_dinp = a_q;
        state_d = ST_PUSH_B;
      end
      ST_PUSH_B: begin
        cp_dpsh = 1'b1;
        cp_dinp = b_q;
        state_d = ST_START;
      end
      ST_START: begin
        cp_start = 1'b1;
        wd_d     = '0;
        state_d  = ST_BUSY;
      end
      ST_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (cp_ready) begin
          state_d = ST_RD_HI;
        end else if (wd_q == TOW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RD_HI: begin
        cp_dpop = 1'b1;
        hi_d    = cp_dout;
        state_d = ST_RD_LO;
      end
      // Second pop swaps the co-processor words back into place.
      ST_RD_LO: begin
        cp_dpop = 1'b1;
        lo_d    = cp_dout;
        state_d = ST_CORR;
      end
      // Co-processor accumulates onto its previous high word; remove it.
      ST_CORR: begin
        res_d     = {hi_q, lo_q} - {{CP_W{1'b0}}, prev_hi_q};
        err_d     = 1'b0;
        prev_hi_d = hi_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE) && !fault_q && !rb;
  assign res_valid = (state_q == ST_DONE);
  assign res       = res_q;
  assign res_err   = err_q;
  assign fault     = fault_q;

endmodule : copro_host
`default_nettype wire

// File: tb/tb_copro_host.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_copro_host : directed bench with behavioural multiply co-proc    |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_copro_host;

  logic        ck = 1'b0;
  logic        rb;
  logic        req_valid, req_ready;
  logic [31:0] op_a, op_b;
  logic        res_valid, res_ready;
  logic [63:0] res;
  logic        res_err, fault;
  logic        cp_start, cp_ready, cp_dpsh, cp_dpop;
  logic [31:0] cp_dinp, cp_dout;

  logic        stub;
  int          n_cmp = 0;
  int          n_err = 0;
  int          viol  = 0;

  always #5 ck = ~ck;

  copro_host dut (
    .ck        (ck),
    .rb        (rb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .res_err   (res_err),
    .fault     (fault),
    .cp_start  (cp_start),
    .cp_ready  (cp_ready),
    .cp_dpsh   (cp_dpsh),
    .cp_dinp   (cp_dinp),
    .cp_dpop   (cp_dpop),
    .cp_dout   (cp_dout)
  );

  // Co-processor model: push shifts A<-B<-din, result = A*B + old high
  // word 33 cycles after start, pop swaps high/low words.
  logic [31:0] m_a, m_b, m_hi, m_lo;
  logic [5:0]  m_cnt;

  always @(posedge ck) begin
    if (rb) begin
      m_a <= '0; m_b <= '0; m_hi <= '0; m_lo <= '0; m_cnt <= '0;
    end else begin
      if (cp_dpsh) begin
        m_a <= m_b;
        m_b <= cp_dinp;
      end
      if (cp_start) begin
        m_cnt <= 6'd33;
      end else if (m_cnt != 6'd0) begin
        m_cnt <= m_cnt - 6'd1;
        if (m_cnt == 6'd1)
          {m_hi, m_lo} <= {32'd0, m_a} * {32'd0, m_b} + {32'd0, m_hi};
      end
      if (cp_dpop) begin
        m_hi <= m_lo;
        m_lo <= m_hi;
      end
    end
  end

  assign cp_ready = (m_cnt == 6'd1) && !stub;
  assign cp_dout  = m_hi;

  always @(negedge ck) begin
    if (rb === 1'b0) begin
      if ((int'(cp_dpsh) + int'(cp_start) + int'(cp_dpop)) > 1) viol++;
      if (res_valid && (cp_dpsh || cp_start || cp_dpop)) viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] er, input logic ee, input int lat,
                        input bit hold);
    int w = 0;
    int c;
    int bad;
    logic [63:0] snap;
    while (!req_ready && w < 100) begin
      tick();
      w++;
    end
    chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    op_a      = a;
    op_b      = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    c = 1;
    while (!res_valid && c < 200) begin
      tick();
      c++;
    end
    chk({tag, " latency"}, 64'(c), 64'(lat));
    chk({tag, " res"}, res, er);
    chk({tag, " res_err"}, 64'(res_err), 64'(ee));
    if (hold) begin
      snap = res;
      bad  = 0;
      repeat (10) begin
        tick();
        if (res !== snap || req_ready !== 1'b0 || res_valid !== 1'b1 ||
            cp_dpsh !== 1'b0 || cp_start !== 1'b0 || cp_dpop !== 1'b0) bad++;
      end
      chk({tag, " backpressure hold"}, 64'(bad), 64'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, " res_valid drop"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    int bad;
    rb        = 1'b1;
    req_valid = 1'b0;
    res_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    stub      = 1'b0;
    repeat (3) tick();
    chk("reset outputs",
        {res, 64'({res_valid, res_err, fault, req_ready, cp_start, cp_dpsh, cp_dpop})},
        128'd0);
    chk("reset cp_dinp", 64'(cp_dinp), 64'd0);
    rb = 1'b0;
    tick();
    chk("idle req_ready", 64'(req_ready), 64'd1);

    run_op("3x5",   32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, 40, 1'b0);
    run_op("max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 40, 1'b0);
    run_op("2x3",   32'd2, 32'd3, 64'h6, 1'b0, 40, 1'b0);
    run_op("0xN",   32'd0, 32'h1234_5678, 64'h0, 1'b0, 40, 1'b0);
    run_op("1xMAX", 32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, 40, 1'b0);
    run_op("bp",    32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 40, 1'b1);

    // Co-processor never answers: watchdog must expire and latch fault.
    stub = 1'b1;
    run_op("tmo", 32'd5, 32'd6, 64'h0, 1'b1, 68, 1'b0);
    chk("tmo fault", 64'(fault), 64'd1);
    req_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (req_ready !== 1'b0 || cp_dpsh !== 1'b0 || res_valid !== 1'b0) bad++;
    end
    req_valid = 1'b0;
    chk("fault blocks requests", 64'(bad), 64'd0);
    chk("fault sticky", 64'(fault), 64'd1);
    rb = 1'b1;
    tick();
    chk("fault cleared by reset", 64'(fault), 64'd0);
    rb   = 1'b0;
    stub = 1'b0;
    tick();

    // Reset while BUSY aborts the operation.
    op_a      = 32'd4;
    op_b      = 32'd4;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    rb = 1'b1;
    tick();
    chk("abort outputs",
        {res, 64'({res_valid, res_err, fault, req_ready, cp_start, cp_dpsh, cp_dpop})},
        128'd0);
    rb = 1'b0;
    tick();
    chk("abort idle", 64'({req_ready, res_valid}), 64'b10);
    run_op("7x9", 32'd7, 32'd9, 64'd63, 1'b0, 40, 1'b0);

    chk("protocol exclusivity", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_copro_host
`default_nettype wire
